// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the common-data-bus arbiter slice:
//   - CDB field widths and the reserved "no tag" value (`None == 0)
//   - the per-cycle action decoded by the arbiter
//   - a round-robin candidate helper
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int CDB_TAG_W    = 4;
    localparam int CDB_VAL_W    = 32;
    localparam int CDB_ADDR_W   = 32;
    localparam int CDB_RD_W     = 5;

    // A result carrying this tag has no destination; it is accepted from the
    // producer but never broadcast.
    localparam int CDB_TAG_NONE = 0;

    // What the output register does on the next edge.
    typedef enum logic [1:0] {
        CDB_HOLD  = 2'd0,
        CDB_FLUSH = 2'd1,
        CDB_GRANT = 2'd2,
        CDB_IDLE  = 2'd3
    } cdb_action_e;

    // Index visited at step 'offset' of a round-robin search that begins
    // just after the previous winner.
    function automatic int rr_candidate(input int last_grant,
                                        input int offset,
                                        input int nreq);
        return (last_grant + 1 + offset) % nreq;
    endfunction

endpackage

// File: rtl/cdb_arbiter_queue.sv
// ---------------------------------------------------------------------------
// cdb_queue
// DEPTH-entry FIFO holding one pending CDB result {tag, val, addr, rd_idx}
// per entry. DEPTH must be a power of two (>= 2) so the pointers wrap
// naturally.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   push, pop, flush      enqueue / dequeue / empty the queue (flush wins)
//   push_tag/val/addr/rd  entry written on push
//   count                 number of valid entries (0..DEPTH)
//   head_tag/val/addr/rd  oldest entry (meaningful only when count > 0)
// ---------------------------------------------------------------------------
module cdb_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = CDB_TAG_W
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic [CDB_VAL_W-1:0]     push_val,
    input  logic [CDB_ADDR_W-1:0]    push_addr,
    input  logic [CDB_RD_W-1:0]      push_rd_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic [TAG_W-1:0]         head_tag,
    output logic [CDB_VAL_W-1:0]     head_val,
    output logic [CDB_ADDR_W-1:0]    head_addr,
    output logic [CDB_RD_W-1:0]      head_rd_idx
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0]      mem_tag   [DEPTH];
    logic [CDB_VAL_W-1:0]  mem_val   [DEPTH];
    logic [CDB_ADDR_W-1:0] mem_addr  [DEPTH];
    logic [CDB_RD_W-1:0]   mem_rd    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow locally so the queue stays coherent
    // even if a caller asserts push when full or pop when empty.
    assign do_push = push && !flush && (count != FULL_COUNT);
    assign do_pop  = pop  && !flush && (count != '0);

    // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves
    // the count unchanged while both pointers advance.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents of empty slots are never observed, so no reset.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_tag[wr_ptr]  <= push_tag;
            mem_val[wr_ptr]  <= push_val;
            mem_addr[wr_ptr] <= push_addr;
            mem_rd[wr_ptr]   <= push_rd_idx;
        end
    end

    assign head_tag    = mem_tag[rd_ptr];
    assign head_val    = mem_val[rd_ptr];
    assign head_addr   = mem_addr[rd_ptr];
    assign head_rd_idx = mem_rd[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the single common data bus between NREQ result producers. Each
// producer feeds its own cdb_queue; one non-empty queue head is granted per
// cycle in round-robin order and loaded into the registered CDB broadcast.
// A branch mispredict (predict_fail) empties every queue and clears the bus.
//
// Ports:
//   clk_in, rst_in    clock, asynchronous active-high reset
//   rdy_in            global enable; low freezes queues and CDB outputs
//   predict_fail      mispredict flush (acts only while rdy_in is high)
//   req_valid[i]      producer i offers a result
//   req_ready[i]      queue i can accept (independent of a same-cycle pop)
//   req_tag/val/addr/rd_idx   producer result fields, slice i per producer
//   cdb_active        broadcast valid
//   cdb_tag/val/addr/rd_idx   broadcast fields (zero when not active)
// ---------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 2,
    parameter int TAG_W = CDB_TAG_W
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       predict_fail,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*TAG_W-1:0]      req_tag,
    input  logic [NREQ*CDB_VAL_W-1:0]  req_val,
    input  logic [NREQ*CDB_ADDR_W-1:0] req_addr,
    input  logic [NREQ*CDB_RD_W-1:0]   req_rd_idx,
    output logic                       cdb_active,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [CDB_VAL_W-1:0]       cdb_val,
    output logic [CDB_ADDR_W-1:0]      cdb_addr,
    output logic [CDB_RD_W-1:0]        cdb_rd_idx
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [NREQ-1:0][CNT_W-1:0]      q_count;
    logic [NREQ-1:0][TAG_W-1:0]      head_tag;
    logic [NREQ-1:0][CDB_VAL_W-1:0]  head_val;
    logic [NREQ-1:0][CDB_ADDR_W-1:0] head_addr;
    logic [NREQ-1:0][CDB_RD_W-1:0]   head_rd_idx;

    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] eligible;
    logic            flush;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    cdb_action_e      action;

    // Pushes are already blocked by predict_fail; the flush itself only
    // takes effect while the pipeline is enabled.
    assign flush = rdy_in && predict_fail;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        // Eligibility uses the count at the start of the cycle, so an entry
        // pushed this cycle can only be granted on a later one.
        assign eligible[i]  = (q_count[i] != '0);
        assign req_ready[i] = rdy_in && !rst_in && (q_count[i] != FULL_COUNT);

        // `None-tagged results complete the handshake but are dropped here.
        assign push[i] = req_valid[i] && req_ready[i] && !predict_fail &&
                         (req_tag[i*TAG_W +: TAG_W] != TAG_W'(CDB_TAG_NONE));
        assign pop[i]  = (action == CDB_GRANT) && (grant_idx == IDX_W'(i));

        cdb_queue #(
            .DEPTH (DEPTH),
            .TAG_W (TAG_W)
        ) u_queue (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .push        (push[i]),
            .pop         (pop[i]),
            .flush       (flush),
            .push_tag    (req_tag[i*TAG_W +: TAG_W]),
            .push_val    (req_val[i*CDB_VAL_W +: CDB_VAL_W]),
            .push_addr   (req_addr[i*CDB_ADDR_W +: CDB_ADDR_W]),
            .push_rd_idx (req_rd_idx[i*CDB_RD_W +: CDB_RD_W]),
            .count       (q_count[i]),
            .head_tag    (head_tag[i]),
            .head_val    (head_val[i]),
            .head_addr   (head_addr[i]),
            .head_rd_idx (head_rd_idx[i])
        );
    end

    // Round-robin search starting just after the previous winner; the first
    // eligible queue in that order is granted.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = rr_candidate(int'(last_grant), k, NREQ);
            cand_idx = IDX_W'(cand);
            if (!grant_valid && eligible[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Pause outranks flush, which outranks a normal grant.
    always_comb begin
        if (!rdy_in) begin
            action = CDB_HOLD;
        end else if (predict_fail) begin
            action = CDB_FLUSH;
        end else if (grant_valid) begin
            action = CDB_GRANT;
        end else begin
            action = CDB_IDLE;
        end
    end

    // Registered CDB broadcast and round-robin pointer. While paused the
    // outputs simply hold; consumers ignore the bus in that state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_active <= 1'b0;
            cdb_tag    <= '0;
            cdb_val    <= '0;
            cdb_addr   <= '0;
            cdb_rd_idx <= '0;
            last_grant <= '0;
        end else begin
            case (action)
                CDB_GRANT: begin
                    cdb_active <= 1'b1;
                    cdb_tag    <= head_tag[grant_idx];
                    cdb_val    <= head_val[grant_idx];
                    cdb_addr   <= head_addr[grant_idx];
                    cdb_rd_idx <= head_rd_idx[grant_idx];
                    last_grant <= grant_idx;
                end
                CDB_FLUSH: begin
                    cdb_active <= 1'b0;
                    cdb_tag    <= '0;
                    cdb_val    <= '0;
                    cdb_addr   <= '0;
                    cdb_rd_idx <= '0;
                    last_grant <= '0;
                end
                CDB_IDLE: begin
                    cdb_active <= 1'b0;
                    cdb_tag    <= '0;
                    cdb_val    <= '0;
                    cdb_addr   <= '0;
                    cdb_rd_idx <= '0;
                end
                default: begin
                    cdb_active <= cdb_active;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter (NREQ=2, DEPTH=2, TAG_W=4). A
// queue-based reference model tracks every accepted result; a vector table
// and a few hand-written sequences cover the directed corner cases, then a
// randomized run is checked against the model.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NREQ  = 2;
    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         rdy_in;
    logic         predict_fail;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [7:0]   req_tag;
    logic [63:0]  req_val;
    logic [63:0]  req_addr;
    logic [9:0]   req_rd_idx;
    logic         cdb_active;
    logic [3:0]   cdb_tag;
    logic [31:0]  cdb_val;
    logic [31:0]  cdb_addr;
    logic [4:0]   cdb_rd_idx;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [31:0] addr;
        logic [4:0]  rd;
    } entry_t;

    typedef struct {
        logic [1:0] v;
        logic [3:0] t0;
        logic [3:0] t1;
        logic       rdy;
        logic       pf;
        logic [1:0] exp_ready;
        logic       exp_active;
        logic [3:0] exp_tag;
    } vec_t;

    entry_t mq [2][$];
    int     model_last;
    logic   model_active;
    entry_t model_out;

    int checks = 0;
    int errors = 0;

    vec_t vecs [26];

    cdb_arbiter #(
        .NREQ  (NREQ),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .predict_fail (predict_fail),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_tag      (req_tag),
        .req_val      (req_val),
        .req_addr     (req_addr),
        .req_rd_idx   (req_rd_idx),
        .cdb_active   (cdb_active),
        .cdb_tag      (cdb_tag),
        .cdb_val      (cdb_val),
        .cdb_addr     (cdb_addr),
        .cdb_rd_idx   (cdb_rd_idx)
    );

    initial begin
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] val_of(input logic [3:0] t);
        return 32'hC0DE_0000 | {28'h0, t};
    endfunction

    function automatic logic [31:0] addr_of(input logic [3:0] t);
        return 32'h0000_0100 + {26'h0, t, 2'b00};
    endfunction

    function automatic logic [4:0] rd_of(input logic [3:0] t);
        return {1'b0, t} + 5'd1;
    endfunction

    function automatic vec_t mkv(input logic [1:0] v, input int t0, input int t1,
                                 input logic rdy, input logic pf,
                                 input logic [1:0] er, input logic ea, input int et);
        vec_t r;
        r.v = v; r.t0 = 4'(t0); r.t1 = 4'(t1); r.rdy = rdy; r.pf = pf;
        r.exp_ready = er; r.exp_active = ea; r.exp_tag = 4'(et);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] actual,
                               input logic [79:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] tag,
                           input logic [31:0] val, input logic [31:0] addr,
                           input logic [4:0] rd);
        req_valid[i]          = v;
        req_tag[i*4 +: 4]     = tag;
        req_val[i*32 +: 32]   = val;
        req_addr[i*32 +: 32]  = addr;
        req_rd_idx[i*5 +: 5]  = rd;
    endtask

    task automatic set_req_tag(input int i, input logic v, input logic [3:0] tag);
        set_req(i, v, tag, val_of(tag), addr_of(tag), rd_of(tag));
    endtask

    // Reference model: per-requester FIFOs of accepted results, a
    // round-robin pointer and the broadcast currently on the bus.
    task automatic model_reset();
        mq[0].delete();
        mq[1].delete();
        model_last   = 0;
        model_active = 1'b0;
        model_out    = '0;
    endtask

    function automatic logic [1:0] model_ready();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) begin
            r[i] = rdy_in && !rst_in && (mq[i].size() < DEPTH);
        end
        return r;
    endfunction

    task automatic model_edge(input logic [1:0] ready_pre);
        int     win;
        int     idx;
        entry_t e;
        if (!rdy_in) return;
        if (predict_fail) begin
            model_reset();
            return;
        end
        win = -1;
        for (int k = 0; k < 2; k++) begin
            idx = (model_last + 1 + k) % 2;
            if (win < 0 && mq[idx].size() > 0) win = idx;
        end
        if (win >= 0) begin
            model_out    = mq[win].pop_front();
            model_active = 1'b1;
            model_last   = win;
        end else begin
            model_active = 1'b0;
            model_out    = '0;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && ready_pre[i] && req_tag[i*4 +: 4] != 4'd0) begin
                e.tag  = req_tag[i*4 +: 4];
                e.val  = req_val[i*32 +: 32];
                e.addr = req_addr[i*32 +: 32];
                e.rd   = req_rd_idx[i*5 +: 5];
                mq[i].push_back(e);
            end
        end
    endtask

    // One clock of stimulus: inputs were set just after a falling edge.
    // Checks req_ready before the rising edge and the CDB after it against
    // the model, and hands the observed values back for directed checks.
    task automatic applyStimulus(input string name, output logic [1:0] ready_seen,
                                 output logic [73:0] cdb_seen);
        logic [1:0] ready_pre;
        #1;
        ready_pre  = model_ready();
        ready_seen = req_ready;
        checkOutput({name, " ready"}, 80'(req_ready), 80'(ready_pre));
        @(posedge clk_in);
        model_edge(ready_pre);
        #1;
        cdb_seen = {cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_rd_idx};
        checkOutput({name, " cdb"}, 80'(cdb_seen), 80'({model_active, model_out}));
        @(negedge clk_in);
    endtask

    initial begin
        logic [1:0]  rs;
        logic [73:0] cs;
        logic [73:0] exp_cdb;
        logic [3:0]  pend1 [$];
        logic [3:0]  seen1 [$];
        logic        saw_full;
        int          p0;

        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        predict_fail = 1'b0;
        req_valid    = '0;
        req_tag      = '0;
        req_val      = '0;
        req_addr     = '0;
        req_rd_idx   = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk_in);
        #1;
        checkOutput("reset ready", 80'(req_ready), 80'(2'b00));
        checkOutput("reset cdb", 80'({cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_rd_idx}), 80'(0));
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        checkOutput("post-reset ready", 80'(req_ready), 80'(2'b11));
        @(negedge clk_in);

        // Single push: visible one edge after the push edge, then idle again
        set_req(0, 1'b1, 4'd3, 32'h1234, 32'h100, 5'd5);
        set_req(1, 1'b0, 4'd0, '0, '0, '0);
        applyStimulus("single push edge", rs, cs);
        checkOutput("single t", 80'(cs), 80'(0));
        set_req(0, 1'b0, 4'd0, '0, '0, '0);
        applyStimulus("single bcast", rs, cs);
        checkOutput("single t+1", 80'(cs), 80'({1'b1, 4'd3, 32'h1234, 32'h100, 5'd5}));
        applyStimulus("single after", rs, cs);
        checkOutput("single t+2", 80'(cs), 80'(0));

        // Directed vector table: contention, pause, `None, flush
        vecs[0]  = mkv(2'b10, 0, 7,  1, 0, 2'b11, 0, 0);
        vecs[1]  = mkv(2'b00, 0, 0,  1, 0, 2'b11, 1, 7);
        vecs[2]  = mkv(2'b11, 1, 9,  1, 0, 2'b11, 0, 0);
        vecs[3]  = mkv(2'b11, 2, 10, 1, 0, 2'b11, 1, 1);
        vecs[4]  = mkv(2'b00, 0, 0,  1, 0, 2'b01, 1, 9);
        vecs[5]  = mkv(2'b00, 0, 0,  1, 0, 2'b11, 1, 2);
        vecs[6]  = mkv(2'b00, 0, 0,  1, 0, 2'b11, 1, 10);
        vecs[7]  = mkv(2'b00, 0, 0,  1, 0, 2'b11, 0, 0);
        vecs[8]  = mkv(2'b11, 3, 11, 1, 0, 2'b11, 0, 0);
        vecs[9]  = mkv(2'b11, 4, 12, 1, 0, 2'b11, 1, 3);
        vecs[10] = mkv(2'b11, 5, 13, 0, 0, 2'b00, 1, 3);
        vecs[11] = mkv(2'b11, 5, 13, 0, 0, 2'b00, 1, 3);
        vecs[12] = mkv(2'b11, 5, 13, 0, 0, 2'b00, 1, 3);
        vecs[13] = mkv(2'b00, 0, 0,  1, 0, 2'b01, 1, 11);
        vecs[14] = mkv(2'b00, 0, 0,  1, 0, 2'b11, 1, 4);
        vecs[15] = mkv(2'b00, 0, 0,  1, 0, 2'b11, 1, 12);
        vecs[16] = mkv(2'b00, 0, 0,  1, 0, 2'b11, 0, 0);
        vecs[17] = mkv(2'b01, 0, 0,  1, 0, 2'b11, 0, 0);
        vecs[18] = mkv(2'b00, 0, 0,  1, 0, 2'b11, 0, 0);
        vecs[19] = mkv(2'b11, 6, 14, 1, 0, 2'b11, 0, 0);
        vecs[20] = mkv(2'b11, 8, 15, 1, 0, 2'b11, 1, 6);
        vecs[21] = mkv(2'b11, 9, 13, 1, 1, 2'b01, 0, 0);
        vecs[22] = mkv(2'b00, 0, 0,  1, 0, 2'b11, 0, 0);
        vecs[23] = mkv(2'b10, 0, 5,  1, 0, 2'b11, 0, 0);
        vecs[24] = mkv(2'b00, 0, 0,  1, 0, 2'b11, 1, 5);
        vecs[25] = mkv(2'b00, 0, 0,  1, 0, 2'b11, 0, 0);

        for (int n = 0; n < 26; n++) begin
            set_req_tag(0, vecs[n].v[0], vecs[n].t0);
            set_req_tag(1, vecs[n].v[1], vecs[n].t1);
            rdy_in       = vecs[n].rdy;
            predict_fail = vecs[n].pf;
            applyStimulus($sformatf("vec%0d", n), rs, cs);
            exp_cdb = vecs[n].exp_active ?
                      {1'b1, vecs[n].exp_tag, val_of(vecs[n].exp_tag),
                       addr_of(vecs[n].exp_tag), rd_of(vecs[n].exp_tag)} : '0;
            checkOutput($sformatf("vec%0d table ready", n), 80'(rs), 80'(vecs[n].exp_ready));
            checkOutput($sformatf("vec%0d table cdb", n), 80'(cs), 80'(exp_cdb));
        end
        rdy_in       = 1'b1;
        predict_fail = 1'b0;

        // Backpressure: req1 offers three results while req0 streams
        pend1    = '{4'd11, 4'd12, 4'd13};
        seen1    = {};
        saw_full = 1'b0;
        p0       = 1;
        for (int c = 0; c < 16; c++) begin
            set_req_tag(0, c < 8, 4'(p0));
            set_req_tag(1, pend1.size() > 0, (pend1.size() > 0) ? pend1[0] : 4'd0);
            applyStimulus("bp", rs, cs);
            if (!rs[1]) saw_full = 1'b1;
            if (rs[0] && c < 8) p0++;
            if (rs[1] && pend1.size() > 0) void'(pend1.pop_front());
            if (cs[73] && cs[72:69] >= 4'd11) seen1.push_back(cs[72:69]);
        end
        checkOutput("bp req1 saw full", 80'(saw_full), 80'(1));
        checkOutput("bp req1 count", 80'(seen1.size()), 80'(3));
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp req1 order%0d", k),
                        80'((k < seen1.size()) ? seen1[k] : 4'd0), 80'(11 + k));
        end

        // Asynchronous reset while a broadcast is on the bus
        set_req_tag(0, 1'b1, 4'd5);
        set_req_tag(1, 1'b0, 4'd0);
        applyStimulus("rst push", rs, cs);
        set_req_tag(0, 1'b0, 4'd0);
        applyStimulus("rst bcast", rs, cs);
        checkOutput("rst pre active", 80'(cdb_active), 80'(1));
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        checkOutput("rst async cdb", 80'({cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_rd_idx}), 80'(0));
        checkOutput("rst async ready", 80'(req_ready), 80'(2'b00));
        @(posedge clk_in);
        #1;
        checkOutput("rst held ready", 80'(req_ready), 80'(2'b00));
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        checkOutput("rst release ready", 80'(req_ready), 80'(2'b11));

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rdy_in       = ($urandom_range(9) != 0);
            predict_fail = ($urandom_range(24) == 0);
            for (int i = 0; i < 2; i++) begin
                set_req(i, 1'($urandom_range(1)), 4'($urandom_range(15)),
                        $urandom, $urandom, 5'($urandom_range(31)));
            end
            applyStimulus("rand", rs, cs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
